keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low matrix keypad and emits one 4-bit key code per debounced press.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/sync_2ff.sv | 23 ++
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and lookup helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {SCAN, DEBOUNCE, LOAD, STROBE, RELEASE} kp_state_t;

  typedef logic [3:0] key_code_t;

  // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
  function automatic key_code_t keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    key_code_t code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] row);
    logic [1:0] idx;
    if (!row[0])      idx = 2'd0;
    else if (!row[1]) idx = 2'd1;
    else if (!row[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
    return ~(4'b0001 << col_idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up rows read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, press/release debounce, one ready pulse per key.
//  state    | meaning
//  SCAN     | drive one column, look for any low row at the end of its slot
//  DEBOUNCE | column held, require DEBOUNCE_CYCLES consecutive lows on the latched row
//  LOAD     | one cycle, update tecla from the latched row/column
//  STROBE   | ready high for READY_LEN cycles
//  RELEASE  | column held, require DEBOUNCE_CYCLES consecutive highs, then resume scan
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd1000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000,
  parameter logic [7:0]  READY_LEN       = 8'd4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output key_code_t tecla,
  output logic      ready,
  output logic      busy
);

  localparam int DIV_W = (SCAN_DIV > 16'd1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 20'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RDY_W = (READY_LEN > 8'd1) ? $clog2(READY_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 16'd1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 20'd1);
  localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_LEN - 8'd1);

  logic [3:0]       row_s;
  kp_state_t        state;
  logic [1:0]       col_idx;
  logic [1:0]       row_sel;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic [RDY_W-1:0] rdy_cnt;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      col     <= 4'b1110;
      row_sel <= 2'd0;
      div_cnt <= '0;
      db_cnt  <= '0;
      rdy_cnt <= '0;
      tecla   <= 4'h0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (row_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
            end else begin
              row_sel <= lowest_low(row_s);
              db_cnt  <= '0;
              busy    <= 1'b1;
              state   <= DEBOUNCE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DEBOUNCE: begin
          if (!row_s[row_sel]) begin
            if (db_cnt == DB_LAST) begin
              db_cnt <= '0;
              state  <= LOAD;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end else begin
            // bounce: give up on this column and move on
            busy    <= 1'b0;
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= col_drive(col_idx + 2'd1);
            state   <= SCAN;
          end
        end

        LOAD: begin
          tecla   <= keymap(row_sel, col_idx);
          rdy_cnt <= '0;
          state   <= STROBE;
        end

        STROBE: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (rdy_cnt == RDY_LAST) begin
            ready  <= 1'b0;
            db_cnt <= '0;
            state  <= RELEASE;
          end else begin
            rdy_cnt <= rdy_cnt + RDY_W'(1);
          end
        end

        RELEASE: begin
          if (row_s[row_sel]) begin
            // the current high is the last one needed when the count already holds DB_LAST
            if (db_cnt == DB_LAST) begin
              db_cnt  <= '0;
              busy    <= 1'b0;
              div_cnt <= '0;
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
              state   <= SCAN;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end else begin
            db_cnt <= '0;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad bench: a key-matrix model drives rows from col; a scoreboard checks each ready pulse.
module tb_keypad_scanner;

  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       ready;
  logic       busy;

  logic [15:0] keys = '0;
  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (16'd4),
    .DEBOUNCE_CYCLES (20'd8),
    .READY_LEN       (8'd2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .col   (col),
    .tecla (tecla),
    .ready (ready),
    .busy  (busy)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       prev_ready = 1'b0;
  logic       prev_rst = 1'b1;
  logic [3:0] prev_tecla = 4'h0;
  logic [3:0] rise_tecla = 4'h0;
  logic [3:0] exp_code;
  int         hi_len = 0;
  bit         pend = 1'b0;

  always @(negedge clk) begin
    if (reset || prev_rst) begin
      pend   = 1'b0;
      hi_len = 0;
    end else begin
      if (pend) begin
        check("tecla_leads_ready", 32'(ready && !prev_ready), 32'd1);
        pend = 1'b0;
      end
      if (tecla != prev_tecla) pend = 1'b1;
      if (ready && !prev_ready) begin
        check("tecla_stable_before_rise", 32'(tecla), 32'(prev_tecla));
        check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_code = exp_q.pop_front();
          check("tecla_code", 32'(tecla), 32'(exp_code));
        end
        rise_tecla = tecla;
        hi_len     = 1;
      end else if (ready) begin
        hi_len++;
      end
      if (!ready && prev_ready) begin
        check("ready_len", 32'(hi_len), 32'(RL));
        check("tecla_at_fall", 32'(tecla), 32'(rise_tecla));
      end
    end
    prev_ready = ready;
    prev_tecla = tecla;
    prev_rst   = reset;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_col", 32'(col), 32'hE);
    check("rst_tecla", 32'(tecla), 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_q_empty(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // key bounces: 3 cycles closed, 3 open, per bounce; ends closed
  task automatic press(input int r, input int c, input int bounces);
    for (int b = 0; b < bounces; b++) begin
      keys[r*4+c] = 1'b1;
      cyc(3);
      keys[r*4+c] = 1'b0;
      cyc(3);
    end
    keys[r*4+c] = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    int c;
    logic [3:0] col0;

    // idle scan pattern
    do_reset();
    for (int i = 0; i < 32; i++) begin
      check("idle_scan_col", 32'(col), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
      cyc(1);
    end

    // r1/c2 held 40 cycles, busy release timing
    exp_q.push_back(kmap[1*4+2]);
    press(1, 2, 0);
    cyc(40);
    check("busy_while_held", 32'(busy), 32'd1);
    keys = '0;
    k = 0;
    while (busy && k < 50) begin
      cyc(1);
      k++;
    end
    check("busy_release_delay", 32'(k), 32'd10);
    cyc(5);
    check("q_after_r1c2", 32'(exp_q.size()), 32'd0);

    // r3/c0 with bounces
    exp_q.push_back(kmap[3*4+0]);
    press(3, 0, 3);
    cyc(60);
    keys = '0;
    wait_busy_low("busy_low_r3c0", 100);
    cyc(5);

    // r0/c3 long hold, no repeat, scan resumes
    exp_q.push_back(kmap[0*4+3]);
    press(0, 3, 0);
    cyc(200);
    keys = '0;
    wait_busy_low("busy_low_r0c3", 100);
    col0 = col;
    k = 0;
    while (col == col0 && k < 20) begin
      cyc(1);
      k++;
    end
    check("scan_resumes", 32'(col != col0), 32'd1);
    check("q_after_hold", 32'(exp_q.size()), 32'd0);

    // two rows in c1: lowest wins, second reported after first releases
    exp_q.push_back(kmap[0*4+1]);
    exp_q.push_back(kmap[2*4+1]);
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    cyc(60);
    keys[0*4+1] = 1'b0;
    wait_q_empty("second_key_reported", 300);
    cyc(10);
    keys = '0;
    wait_busy_low("busy_low_two_keys", 100);

    // other-column key while busy is ignored
    exp_q.push_back(kmap[2*4+2]);
    press(2, 2, 0);
    wait_q_empty("r2c2_reported", 200);
    keys[0*4+0] = 1'b1;
    cyc(10);
    keys[0*4+0] = 1'b0;
    cyc(5);
    keys = '0;
    wait_busy_low("busy_low_ignore", 100);
    cyc(30);

    // randomized single keys with bounces
    for (int it = 0; it < 10; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      exp_q.push_back(kmap[r*4+c]);
      press(r, c, int'($urandom_range(0, 2)));
      cyc(int'($urandom_range(60, 150)));
      check("busy_rand_held", 32'(busy), 32'd1);
      keys = '0;
      wait_busy_low("busy_low_rand", 100);
      cyc(int'($urandom_range(0, 20)));
      check("q_rand", 32'(exp_q.size()), 32'd0);
    end

    // reset during STROBE: press never reported
    do_reset();
    press(1, 1, 0);
    k = 0;
    while (tecla == 4'h0 && k < 200) begin
      cyc(1);
      k++;
    end
    check("strobe_reached", 32'(tecla), 32'(kmap[1*4+1]));
    reset = 1'b1;
    keys  = '0;
    @(posedge clk);
    #1;
    check("strobe_rst_ready", 32'(ready), 32'd0);
    check("strobe_rst_tecla", 32'(tecla), 32'h0);
    check("strobe_rst_col", 32'(col), 32'hE);
    check("strobe_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc(40);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
